// File: rtl/misr_pkg.sv
// Shared types, defaults and the compression step for the MISR peripheral.
package misr_pkg;

    localparam int unsigned MISR_N_CH = 2;
    localparam int unsigned MISR_W    = 32;
    localparam int unsigned MISR_CNT_W = 32;

    localparam logic [MISR_W-1:0] MISR_POLY_DEFAULT = 32'h04C1_1DB7;
    localparam logic [MISR_W-1:0] MISR_SEED_DEFAULT = 32'h0000_0000;

    // Packed so that {cnt, sig} lines up with the read-data word layout.
    typedef struct packed {
        logic [MISR_CNT_W-1:0] cnt;
        logic [MISR_W-1:0]     sig;
    } misr_state_t;

    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] data,
        input logic [MISR_W-1:0] poly = MISR_POLY_DEFAULT
    );
        return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/misr_channel.sv
// One signature register plus its saturating write counter.
module misr_channel
    import misr_pkg::*;
#(
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_POLY_DEFAULT,
    parameter logic [MISR_W-1:0] MISR_SEED = MISR_SEED_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [MISR_W-1:0]     data_i,
    output logic [MISR_W-1:0]     sig_o,
    output logic [MISR_CNT_W-1:0] cnt_o
);

    misr_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (we_i) begin
            state_d.sig = misr_step(state_q.sig, data_i, MISR_POLY);
            if (state_q.cnt != '1) begin
                state_d.cnt = state_q.cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q.sig <= MISR_SEED;
            state_q.cnt <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign sig_o = state_q.sig;
    assign cnt_o = state_q.cnt;

endmodule

// File: rtl/misr_periph.sv
// Two-channel memory-mapped MISR: strobe legality check, write fan-out and registered read port.
module misr_periph
    import misr_pkg::*;
#(
    parameter int unsigned      NBIT_MISR_DATA = 32,
    parameter int unsigned      NBIT_MISR_ADDR = 64,
    parameter int unsigned      NBIT_AXI_WIDTH = 64,
    parameter logic [31:0]      MISR_POLY      = MISR_POLY_DEFAULT,
    parameter logic [31:0]      MISR_SEED      = MISR_SEED_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                re_misr_i,
    input  logic [1:0]                we_misr_i,
    input  logic [NBIT_MISR_ADDR-1:0] addr_misr_i,
    input  logic [NBIT_MISR_DATA-1:0] data_misr_i,
    output logic [NBIT_AXI_WIDTH-1:0] rdata_o,
    output logic                      rvalid_o,
    output logic                      err_o
);

    logic [MISR_W-1:0]     sig   [MISR_N_CH];
    logic [MISR_CNT_W-1:0] cnt   [MISR_N_CH];
    logic                  illegal;
    logic [1:0]            we_ok;
    logic [1:0]            re_ok;
    logic                  unused_addr;

    logic [NBIT_AXI_WIDTH-1:0] rdata_q, rdata_d;
    logic                      rvalid_q, rvalid_d;
    logic                      err_q, err_d;

    assign unused_addr = ^addr_misr_i;

    assign illegal = (&re_misr_i) | (&we_misr_i) | ((|re_misr_i) & (|we_misr_i));
    assign we_ok   = illegal ? 2'b00 : we_misr_i;
    assign re_ok   = illegal ? 2'b00 : re_misr_i;

    misr_channel #(.MISR_POLY(MISR_POLY), .MISR_SEED(MISR_SEED)) u_ch0 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (we_ok[0]),
        .data_i (data_misr_i),
        .sig_o  (sig[0]),
        .cnt_o  (cnt[0])
    );

    misr_channel #(.MISR_POLY(MISR_POLY), .MISR_SEED(MISR_SEED)) u_ch1 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (we_ok[1]),
        .data_i (data_misr_i),
        .sig_o  (sig[1]),
        .cnt_o  (cnt[1])
    );

    // rdata holds its last value between legal reads.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = |re_ok;
        err_d    = illegal;
        if (re_ok[0]) begin
            rdata_d = {cnt[0], sig[0]};
        end else if (re_ok[1]) begin
            rdata_d = {cnt[1], sig[1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule
